// File: rtl/usb_pkg.sv
// Shared definitions for the USB host transaction path: PID codes (also used by
// the bitstream encoder and receive decoder), controller state encoding and
// packet field widths.
package usb_pkg;

    localparam int ADDR_W = 7;
    localparam int ENDP_W = 4;
    localparam int DATA_W = 64;
    localparam int PID_W  = 4;

    typedef enum logic [PID_W-1:0] {
        PID_OUT   = 4'b0001,
        PID_IN    = 4'b1001,
        PID_DATA0 = 4'b0011,
        PID_ACK   = 4'b0010,
        PID_NAK   = 4'b1010
    } pid_e;

    // Controller states (plain constants so older tools can share them)
    typedef logic [3:0] state_t;
    localparam state_t ST_IDLE      = 4'd0;
    localparam state_t ST_TOKEN     = 4'd1;
    localparam state_t ST_DATA      = 4'd2;
    localparam state_t ST_WAIT_HS   = 4'd3;
    localparam state_t ST_WAIT_DATA = 4'd4;
    localparam state_t ST_HS_ACK    = 4'd5;
    localparam state_t ST_BACKOFF   = 4'd6;
    localparam state_t ST_DONE_OK   = 4'd7;
    localparam state_t ST_DONE_ERR  = 4'd8;

    // Phases of a packet hand-off to the encoder
    typedef logic [1:0] phase_t;
    localparam phase_t PH_OFFER = 2'd0;  // enc_pktready high, waiting for gotpkt
    localparam phase_t PH_SKIP  = 2'd1;  // first cycle after gotpkt, sending not yet valid
    localparam phase_t PH_DRAIN = 2'd2;  // waiting for enc_sending to fall

endpackage

// File: rtl/usb_txn_timer.sv
// Loadable down-counter with a zero flag. Holds at zero instead of wrapping.
module usb_txn_timer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic             zero
);

    logic [WIDTH-1:0] cnt_q;

    // Load takes priority; otherwise count down and stick at zero
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= load_val;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - WIDTH'(1);
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/usb_host_txn_ctrl.sv
// USB host transaction sequencer: drives the encoder through token/data/handshake
// packets for one OUT or IN transaction, retries on NAK, corrupt rx or timeout.
// Optional macro USB_TXN_NAK_BACKOFF_EN: after a NAK with retries left, idle for
// BACKOFF_CYCLES before re-sending the token.
module usb_host_txn_ctrl
    import usb_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int MAX_RETRIES    = 3,
    parameter int BACKOFF_CYCLES = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              txn_req,
    input  logic              txn_is_in,
    input  logic [ADDR_W-1:0] txn_addr,
    input  logic [ENDP_W-1:0] txn_endp,
    input  logic [DATA_W-1:0] txn_wdata,
    output logic              txn_ack,
    output logic              txn_done,
    output logic              txn_ok,
    output logic              txn_err,
    output logic [DATA_W-1:0] txn_rdata,
    output logic              busy,
    output logic              enc_pktready,
    output logic [PID_W-1:0]  enc_pid,
    output logic [ADDR_W-1:0] enc_addr,
    output logic [ENDP_W-1:0] enc_endp,
    output logic [DATA_W-1:0] enc_data,
    input  logic              enc_gotpkt,
    input  logic              enc_sending,
    input  logic              rx_valid,
    input  logic [PID_W-1:0]  rx_pid,
    input  logic [DATA_W-1:0] rx_data,
    input  logic              rx_err
);

    localparam int TO_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int BO_W  = (BACKOFF_CYCLES > 1) ? $clog2(BACKOFF_CYCLES) : 1;
    localparam int TMR_W = (TO_W > BO_W) ? TO_W : BO_W;
    localparam int RC_W  = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;

    localparam logic [RC_W-1:0]  RETRY_MAX = RC_W'(MAX_RETRIES);
    // Timer counts down from N-1 so that zero marks the N-th cycle in the state
    localparam logic [TMR_W-1:0] TO_LOAD   = TMR_W'(TIMEOUT_CYCLES - 1);
`ifdef USB_TXN_NAK_BACKOFF_EN
    localparam logic [TMR_W-1:0] BO_LOAD   = TMR_W'(BACKOFF_CYCLES - 1);
`endif

    state_t            state_q, state_d;
    phase_t            phase_q, phase_d;
    logic [RC_W-1:0]   retry_q, retry_d;
    logic              is_in_q;
    logic [ADDR_W-1:0] addr_q;
    logic [ENDP_W-1:0] endp_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rdata_q, rdata_d;

    logic              fail;
    logic              pkt_done;
    logic              send_state;
    logic              tmr_load;
    logic [TMR_W-1:0]  tmr_load_val;
    logic              tmr_zero;

`ifdef USB_TXN_NAK_BACKOFF_EN
    logic rx_nak;
    assign rx_nak = rx_valid && !rx_err && (rx_pid == PID_NAK);
`endif

    usb_txn_timer #(
        .WIDTH (TMR_W)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (tmr_load_val),
        .zero     (tmr_zero)
    );

    assign txn_ack    = (state_q == ST_IDLE) && txn_req && !rst;
    assign send_state = (state_q == ST_TOKEN) || (state_q == ST_DATA) ||
                        (state_q == ST_HS_ACK);
    assign pkt_done   = send_state && (phase_q == PH_DRAIN) && !enc_sending;

    // Next-state, retry accounting and rx payload capture
    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        retry_d = retry_q;
        rdata_d = rdata_q;
        fail    = 1'b0;

        if (send_state) begin
            case (phase_q)
                PH_OFFER: if (enc_gotpkt) phase_d = PH_SKIP;
                PH_SKIP:  phase_d = PH_DRAIN;
                default:  phase_d = phase_q;
            endcase
        end

        case (state_q)
            ST_IDLE: begin
                if (txn_req) begin
                    state_d = ST_TOKEN;
                    retry_d = '0;
                end
            end
            ST_TOKEN: begin
                if (pkt_done) state_d = is_in_q ? ST_WAIT_DATA : ST_DATA;
            end
            ST_DATA: begin
                if (pkt_done) state_d = ST_WAIT_HS;
            end
            ST_WAIT_HS: begin
                if (rx_valid) begin
                    if (!rx_err && (rx_pid == PID_ACK)) state_d = ST_DONE_OK;
                    else                                fail    = 1'b1;
                end else if (tmr_zero) begin
                    fail = 1'b1;
                end
            end
            ST_WAIT_DATA: begin
                if (rx_valid) begin
                    if (!rx_err && (rx_pid == PID_DATA0)) begin
                        rdata_d = rx_data;
                        state_d = ST_HS_ACK;
                    end else begin
                        fail = 1'b1;
                    end
                end else if (tmr_zero) begin
                    fail = 1'b1;
                end
            end
            ST_HS_ACK: begin
                if (pkt_done) state_d = ST_DONE_OK;
            end
`ifdef USB_TXN_NAK_BACKOFF_EN
            ST_BACKOFF: begin
                if (tmr_zero) state_d = ST_TOKEN;
            end
`endif
            ST_DONE_OK:  state_d = ST_IDLE;
            ST_DONE_ERR: state_d = ST_IDLE;
            default:     state_d = ST_IDLE;
        endcase

        if (fail) begin
            if (retry_q == RETRY_MAX) begin
                state_d = ST_DONE_ERR;
            end else begin
                retry_d = retry_q + RC_W'(1);
`ifdef USB_TXN_NAK_BACKOFF_EN
                state_d = rx_nak ? ST_BACKOFF : ST_TOKEN;
`else
                state_d = ST_TOKEN;
`endif
            end
        end

        // Every entry into a state starts a fresh packet hand-off
        if (state_d != state_q) phase_d = PH_OFFER;
    end

    // Timer is reloaded on every state change; only wait/backoff states look at it
    always_comb begin
        tmr_load     = (state_d != state_q);
`ifdef USB_TXN_NAK_BACKOFF_EN
        tmr_load_val = (state_d == ST_BACKOFF) ? BO_LOAD : TO_LOAD;
`else
        tmr_load_val = TO_LOAD;
`endif
    end

    // State registers and request field capture
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            phase_q <= PH_OFFER;
            retry_q <= '0;
            is_in_q <= 1'b0;
            addr_q  <= '0;
            endp_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            retry_q <= retry_d;
            rdata_q <= rdata_d;
            if (txn_ack) begin
                is_in_q <= txn_is_in;
                addr_q  <= txn_addr;
                endp_q  <= txn_endp;
                wdata_q <= txn_wdata;
            end
        end
    end

    // Encoder fields and requester status decoded from the current state
    always_comb begin
        enc_pid  = '0;
        enc_addr = '0;
        enc_endp = '0;
        enc_data = '0;
        case (state_q)
            ST_TOKEN: begin
                enc_pid  = is_in_q ? PID_IN : PID_OUT;
                enc_addr = addr_q;
                enc_endp = endp_q;
            end
            ST_DATA: begin
                enc_pid  = PID_DATA0;
                enc_data = wdata_q;
            end
            ST_HS_ACK: enc_pid = PID_ACK;
            default:   enc_pid = '0;
        endcase
        enc_pktready = send_state && (phase_q == PH_OFFER);
        busy         = (state_q != ST_IDLE);
        txn_ok       = (state_q == ST_DONE_OK);
        txn_err      = (state_q == ST_DONE_ERR);
        txn_done     = txn_ok || txn_err;
    end

    assign txn_rdata = rdata_q;

endmodule

// File: tb/tb_usb_host_txn_ctrl.sv
// Directed bench for usb_host_txn_ctrl (TIMEOUT_CYCLES=20, MAX_RETRIES=3,
// BACKOFF_CYCLES=16). Inputs are driven and outputs sampled on the falling edge.
module tb_usb_host_txn_ctrl;

`ifdef USB_TXN_NAK_BACKOFF_EN
    localparam int NAK_GAP = 16;
`else
    localparam int NAK_GAP = 0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        txn_req, txn_is_in;
    logic [6:0]  txn_addr;
    logic [3:0]  txn_endp;
    logic [63:0] txn_wdata;
    logic        txn_ack, txn_done, txn_ok, txn_err, busy;
    logic [63:0] txn_rdata;
    logic        enc_pktready;
    logic [3:0]  enc_pid;
    logic [6:0]  enc_addr;
    logic [3:0]  enc_endp;
    logic [63:0] enc_data;
    logic        enc_gotpkt, enc_sending;
    logic        rx_valid, rx_err;
    logic [3:0]  rx_pid;
    logic [63:0] rx_data;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    int t_offer, t_drain, t_rx, t_prev;

    usb_host_txn_ctrl #(
        .TIMEOUT_CYCLES (20),
        .MAX_RETRIES    (3),
        .BACKOFF_CYCLES (16)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .txn_req      (txn_req),
        .txn_is_in    (txn_is_in),
        .txn_addr     (txn_addr),
        .txn_endp     (txn_endp),
        .txn_wdata    (txn_wdata),
        .txn_ack      (txn_ack),
        .txn_done     (txn_done),
        .txn_ok       (txn_ok),
        .txn_err      (txn_err),
        .txn_rdata    (txn_rdata),
        .busy         (busy),
        .enc_pktready (enc_pktready),
        .enc_pid      (enc_pid),
        .enc_addr     (enc_addr),
        .enc_endp     (enc_endp),
        .enc_data     (enc_data),
        .enc_gotpkt   (enc_gotpkt),
        .enc_sending  (enc_sending),
        .rx_valid     (rx_valid),
        .rx_pid       (rx_pid),
        .rx_data      (rx_data),
        .rx_err       (rx_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic start_txn(input string tag, input logic is_in, input logic [6:0] a,
                             input logic [3:0] e, input logic [63:0] d);
        txn_req   = 1'b1;
        txn_is_in = is_in;
        txn_addr  = a;
        txn_endp  = e;
        txn_wdata = d;
        #1;
        chk({tag, " ack"}, txn_ack, 1);
        @(negedge clk);
        txn_req = 1'b0;
        chk({tag, " busy"}, busy, 1);
    endtask

    // Wait for an offered packet, check its fields, accept it and drain
    task automatic take_pkt(input string tag, input logic [3:0] pid, input logic [6:0] a,
                            input logic [3:0] e, input logic [63:0] d);
        int n = 0;
        while (enc_pktready !== 1'b1 && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk({tag, " rdy"}, enc_pktready, 1);
        chk({tag, " pid"}, enc_pid, pid);
        chk({tag, " addr"}, enc_addr, a);
        chk({tag, " endp"}, enc_endp, e);
        chk({tag, " data"}, enc_data, d);
        t_offer = cyc;
        enc_gotpkt = 1'b1;
        @(negedge clk);
        enc_gotpkt  = 1'b0;
        enc_sending = 1'b1;
        chk({tag, " rdy drop"}, enc_pktready, 0);
        @(negedge clk);
        enc_sending = 1'b0;
        @(negedge clk);
        t_drain = cyc;
    endtask

    task automatic rx_pkt(input logic [3:0] pid, input logic [63:0] d, input logic err);
        rx_valid = 1'b1;
        rx_pid   = pid;
        rx_data  = d;
        rx_err   = err;
        @(negedge clk);
        rx_valid = 1'b0;
        rx_err   = 1'b0;
        t_rx     = cyc;
    endtask

    task automatic expect_done(input string tag, input logic ok, input logic err);
        chk({tag, " done"}, txn_done, 1);
        chk({tag, " ok"}, txn_ok, ok);
        chk({tag, " err"}, txn_err, err);
        @(negedge clk);
        chk({tag, " done pulse"}, txn_done, 0);
        chk({tag, " idle"}, busy, 0);
    endtask

    initial begin
        int n;
        rst = 1'b1;
        txn_req = 0; txn_is_in = 0; txn_addr = '0; txn_endp = '0; txn_wdata = '0;
        enc_gotpkt = 0; enc_sending = 0;
        rx_valid = 0; rx_pid = '0; rx_data = '0; rx_err = 0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst busy", busy, 0);
        chk("rst pktready", enc_pktready, 0);
        chk("rst done", txn_done, 0);
        chk("rst pid", enc_pid, 0);
        chk("rst rdata", txn_rdata, 0);
        @(negedge clk);

        // OUT, ACK first time
        start_txn("out1", 1'b0, 7'h2D, 4'h5, 64'hDEADBEEF_01234567);
        take_pkt("out1 tok", 4'b0001, 7'h2D, 4'h5, 64'h0);
        take_pkt("out1 dat", 4'b0011, 7'h0, 4'h0, 64'hDEADBEEF_01234567);
        rx_pkt(4'b0010, 64'h0, 1'b0);
        expect_done("out1", 1'b1, 1'b0);

        // IN, DATA0 returned, ACK handshake
        start_txn("in1", 1'b1, 7'h11, 4'h3, 64'h0);
        take_pkt("in1 tok", 4'b1001, 7'h11, 4'h3, 64'h0);
        rx_pkt(4'b0011, 64'hA5A5_0000_FFFF_1234, 1'b0);
        take_pkt("in1 hs", 4'b0010, 7'h0, 4'h0, 64'h0);
        expect_done("in1", 1'b1, 1'b0);
        chk("in1 rdata", txn_rdata, 64'hA5A5_0000_FFFF_1234);

        // OUT, NAK twice then ACK: three token/data pairs
        start_txn("nak", 1'b0, 7'h05, 4'h2, 64'h0F0F_0F0F_1111_2222);
        for (int i = 0; i < 3; i++) begin
            take_pkt("nak tok", 4'b0001, 7'h05, 4'h2, 64'h0);
            if (i > 0) chk("nak regap", t_offer - t_rx, NAK_GAP);
            take_pkt("nak dat", 4'b0011, 7'h0, 4'h0, 64'h0F0F_0F0F_1111_2222);
            rx_pkt((i < 2) ? 4'b1010 : 4'b0010, 64'h0, 1'b0);
        end
        expect_done("nak", 1'b1, 1'b0);

        // IN, no response: four tokens 20 cycles apart, then error
        start_txn("to", 1'b1, 7'h40, 4'h1, 64'h0);
        for (int i = 0; i < 4; i++) begin
            t_prev = t_drain;
            take_pkt("to tok", 4'b1001, 7'h40, 4'h1, 64'h0);
            if (i > 0) chk("to gap", t_offer - t_prev, 20);
        end
        n = 0;
        while (txn_done !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("to final wait", n, 20);
        expect_done("to", 1'b0, 1'b1);

        // IN, corrupt DATA0 -> retry without ACK; NAK -> retry; clean DATA0
        start_txn("rxe", 1'b1, 7'h33, 4'h7, 64'h0);
        take_pkt("rxe tok1", 4'b1001, 7'h33, 4'h7, 64'h0);
        rx_pkt(4'b0011, 64'hBAD0_BAD0_BAD0_BAD0, 1'b1);
        take_pkt("rxe tok2", 4'b1001, 7'h33, 4'h7, 64'h0);
        chk("rxe err regap", t_offer - t_rx, 0);
        rx_pkt(4'b1010, 64'h0, 1'b0);
        take_pkt("rxe tok3", 4'b1001, 7'h33, 4'h7, 64'h0);
        chk("rxe nak regap", t_offer - t_rx, NAK_GAP);
        rx_pkt(4'b0011, 64'h1122_3344_5566_7788, 1'b0);
        take_pkt("rxe hs", 4'b0010, 7'h0, 4'h0, 64'h0);
        expect_done("rxe", 1'b1, 1'b0);
        chk("rxe rdata", txn_rdata, 64'h1122_3344_5566_7788);

        // Reset during the DATA drain, then a normal transaction
        start_txn("rst", 1'b0, 7'h7F, 4'hF, 64'hCAFE_F00D_0000_0001);
        take_pkt("rst tok", 4'b0001, 7'h7F, 4'hF, 64'h0);
        chk("rst dat rdy", enc_pktready, 1);
        enc_gotpkt = 1'b1;
        @(negedge clk);
        enc_gotpkt  = 1'b0;
        enc_sending = 1'b1;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        enc_sending = 1'b0;
        #1;
        chk("rst mid busy", busy, 0);
        chk("rst mid pktready", enc_pktready, 0);
        chk("rst mid pid", enc_pid, 0);
        chk("rst mid data", enc_data, 0);
        chk("rst mid done", txn_done, 0);
        @(negedge clk);
        chk("rst no done", txn_done, 0);
        start_txn("post", 1'b0, 7'h01, 4'h0, 64'h0000_0000_0000_00AA);
        take_pkt("post tok", 4'b0001, 7'h01, 4'h0, 64'h0);
        take_pkt("post dat", 4'b0011, 7'h0, 4'h0, 64'h0000_0000_0000_00AA);
        rx_pkt(4'b0010, 64'h0, 1'b0);
        expect_done("post", 1'b1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/usb_host_txn_ctrl.md
Name: usb_host_txn_ctrl

Overview:
- Host-side transaction sequencer that owns the serial bitstream encoder.
- Accepts one OUT or IN transaction at a time from a requester and drives the encoder through the packet sequence:
  - OUT: token, then DATA0.
  - IN: token; after the device returns DATA0, the block sends ACK.
- Waits for the device response from the receive decoder, retries on NAK, error or timeout, and reports final status to the requester.

Parameters:
- TIMEOUT_CYCLES, 255: cycles spent waiting for a response before the attempt counts as failed.
- MAX_RETRIES, 3: retries after the first attempt. Total attempts = MAX_RETRIES+1.
- BACKOFF_CYCLES, 16: idle cycles after a NAK before retrying. Used only with NAK_BACKOFF_EN.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- txn_req  in  1  requester has a transaction pending; fields held stable until txn_ack
- txn_is_in  in  1  1 = IN transaction, 0 = OUT transaction
- txn_addr  in  7  device address
- txn_endp  in  4  endpoint
- txn_wdata  in  64  OUT payload
- txn_ack  out  1  one-cycle pulse: request accepted and fields latched
- txn_done  out  1  one-cycle pulse: transaction finished
- txn_ok  out  1  valid with txn_done: success
- txn_err  out  1  valid with txn_done: retries exhausted
- txn_rdata  out  64  IN payload; valid from txn_done until the next accept
- busy  out  1  transaction in progress
- enc_pktready  out  1  packet offered to encoder
- enc_pid  out  4  PID to encode
- enc_addr  out  7  address field
- enc_endp  out  4  endpoint field
- enc_data  out  64  data field
- enc_gotpkt  in  1  encoder has taken the packet
- enc_sending  in  1  encoder is shifting bits
- rx_valid  in  1  decoder has a received packet (one-cycle pulse)
- rx_pid  in  4  received PID
- rx_data  in  64  received payload
- rx_err  in  1  received packet corrupt

Behaviour:
- Reset: every output is 0 and the state is IDLE. Reset mid-transaction aborts it with no txn_done.
- PID codes: OUT=0001, IN=1001, DATA0=0011, ACK=0010, NAK=1010.
- IDLE: when txn_req=1, txn_ack=1 combinationally in the same cycle. On that edge the block latches the fields, clears the retry count and moves to TOKEN.
- Packet send procedure (used by TOKEN, DATA, HS_ACK):
  - enc_pktready=1 with stable enc_* until the cycle enc_gotpkt=1.
  - Then enter the drain phase: ignore the first cycle after gotpkt, then wait until enc_sending=0.
  - Drain end is the next-state trigger.
- TOKEN: sends enc_pid=IN or OUT with the latched addr and endp.
  - After drain: OUT goes to DATA; IN goes to WAIT_DATA.
- DATA: sends DATA0 with latched wdata, then goes to WAIT_HS.
- Wait states: the timeout counter is cleared on entry and increments every cycle. A value of TIMEOUT_CYCLES-1 with no usable rx counts as a failed attempt.
- WAIT_HS:
  - rx_valid with rx_err=0 and ACK: go to DONE_OK.
  - NAK: failed attempt.
  - Any other PID, or rx_err=1: failed attempt.
- WAIT_DATA:
  - rx_valid with DATA0 and rx_err=0: latch rx_data into txn_rdata, go to HS_ACK.
  - NAK, other PID or rx_err=1: failed attempt, no handshake sent.
- HS_ACK: sends ACK (enc_addr, enc_endp, enc_data driven 0), then goes to DONE_OK.
- Failed attempt:
  - If retry count == MAX_RETRIES: go to DONE_ERR.
  - Otherwise increment the count and go to TOKEN (or BACKOFF; see Optional Feature).
- DONE_OK / DONE_ERR: one cycle with txn_done=1 and txn_ok or txn_err=1, then IDLE. A new request can be accepted on the cycle after.
- rx_valid outside the wait states is ignored. rx_valid on the same cycle as timeout expiry: the rx wins.
- busy=1 in every state except IDLE.
- Retry counter is $clog2(MAX_RETRIES+1) bits. Timeout counter is $clog2(TIMEOUT_CYCLES) bits and never wraps.

Optional Feature:
- Macro: USB_TXN_NAK_BACKOFF_EN.
- Defined: a NAK-caused failed attempt with retries remaining enters BACKOFF. The block waits BACKOFF_CYCLES with busy=1 and enc_pktready=0, then goes to TOKEN. Timeout and error failures still retry immediately.
- Undefined: no BACKOFF state; all retries go straight to TOKEN.

Decomposition:
- Package usb_pkg holds:
  - the PID enum (shared with the encoder and decoder);
  - the controller state enum;
  - the packet field widths.
- One sub-module, usb_txn_timer: a loadable down-counter with a zero flag. It serves both the response timeout and the backoff delay.

Test Plan:
- OUT, addr=7'h2D, endp=4'h5, wdata=64'hDEADBEEF_01234567, device ACKs → encoder sees OUT then DATA0 with those fields; one txn_done with txn_ok=1 and no retries.
- IN, addr=7'h11, device returns DATA0 with 64'hA5A5_0000_FFFF_1234 → ACK packet sent; txn_rdata equals that value at txn_done; txn_ok=1.
- OUT with NAK twice then ACK, MAX_RETRIES=3 → exactly 3 token/data pairs sent; txn_ok=1.
- IN with no response, TIMEOUT_CYCLES=20 → 4 IN tokens, each retry exactly 20 cycles after drain; then txn_err=1.
- IN with DATA0 and rx_err=1, then a clean DATA0 → no ACK after the first response, one retry, final txn_ok=1. Repeat with USB_TXN_NAK_BACKOFF_EN defined plus a NAK → 16-cycle gap before re-token.
- rst asserted mid-DATA drain → next cycle all outputs 0 and busy=0; a subsequent request is accepted normally.
